piso_tx_controller: RTL and testbench



---
 rtl/serial_audio_pkg.sv | 20 ++
 rtl/bit_slot_timer.sv | 65 ++++++
 rtl/piso_tx_controller.sv | 131 +++++++++++++
 tb/tb_piso_tx_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_audio_pkg.sv
// Shared widths, frame geometry and state encoding for the serial audio
// transmit path.
package serial_audio_pkg;

    localparam int DATA_W      = 8;
    localparam int SAMPLE_W    = 16;
    localparam int FRAME_SLOTS = 16;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);

    // Slot indices at which a fresh byte is loaded into the PISO
    localparam logic [SLOT_W-1:0] SLOT_FIRST = '0;
    localparam logic [SLOT_W-1:0] SLOT_MID   = SLOT_W'(FRAME_SLOTS / 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_SLOTS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/bit_slot_timer.sv
// Cycle and slot counters for one frame. Besides the current-cycle frame_end
// flag, it exports the decode of the *next* cycle position so the parent can
// register its outputs and still have them line up with the counters.
module bit_slot_timer
    import serial_audio_pkg::*;
#(
    parameter int BIT_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,       // frame begins next cycle
    input  logic              run,         // a frame is in progress this cycle
    output logic              frame_end,   // this cycle is the last of the frame
    output logic              slot_start,  // next cycle is cycle 0 of a slot
    output logic [SLOT_W-1:0] slot_idx,    // slot index of the next cycle
    output logic              bit_clock,   // bit clock level for the next cycle
    output logic              active       // a frame is in progress next cycle
);

    localparam int CYC_W = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_PERIOD - 1);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(BIT_PERIOD / 2);

    logic [CYC_W-1:0]  cyc_reg, cyc_next;
    logic [SLOT_W-1:0] slot_reg, slot_next;
    logic              active_next;

    assign frame_end = run && (cyc_reg == CYC_LAST) && (slot_reg == SLOT_LAST);

    // Next counter position: restart on frame start, advance while running,
    // park at zero otherwise so an idle timer always restarts cleanly.
    always_comb begin
        cyc_next    = '0;
        slot_next   = '0;
        active_next = 1'b0;
        if (start) begin
            active_next = 1'b1;
        end else if (run && !frame_end) begin
            active_next = 1'b1;
            if (cyc_reg == CYC_LAST) begin
                slot_next = slot_reg + 1'b1;
            end else begin
                cyc_next  = cyc_reg + 1'b1;
                slot_next = slot_reg;
            end
        end
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_reg  <= '0;
            slot_reg <= '0;
        end else begin
            cyc_reg  <= cyc_next;
            slot_reg <= slot_next;
        end
    end

    assign slot_start = active_next && (cyc_next == '0);
    assign slot_idx   = slot_next;
    assign bit_clock  = active_next && (cyc_next >= CYC_HALF);
    assign active     = active_next;

endmodule

// File: rtl/piso_tx_controller.sv
// Streams 16-bit samples through an 8-bit PISO as two bytes, MSB first.
// A one-entry holding register decouples the sample source; frames run
// back-to-back while samples keep arriving. Every output is a flop.
module piso_tx_controller
    import serial_audio_pkg::*;
#(
    parameter int BIT_PERIOD = 4
) (
    input  logic                CLOCK_50,
    input  logic                Reset_n,
    input  logic                Enable,
    input  logic [SAMPLE_W-1:0] Sample_Data,
    input  logic                Sample_Valid,
    output logic                Sample_Ready,
    output logic [DATA_W-1:0]   Parallel_Data,
    output logic                Load_Parallel_Data,
    output logic                Shift_Flag,
    output logic                Bit_Clock,
    output logic                Frame_Sync,
    output logic                Busy,
    output logic                Underrun
);

    state_e              state_reg, state_next;
    logic                hold_valid_reg;
    logic [SAMPLE_W-1:0] hold_data_reg;
    // Only the second byte needs to outlive the frame start; the first byte
    // goes straight from the holding register into Parallel_Data.
    logic [DATA_W-1:0]   frame_lo_reg;

    logic                load_reg, shift_reg, bit_clock_reg, frame_sync_reg;
    logic                underrun_reg;
    logic [DATA_W-1:0]   parallel_data_reg;

    logic                run, accept, frame_start;
    logic                frame_end, slot_start, bit_clock_next, active_next;
    logic [SLOT_W-1:0]   slot_idx;
    logic                load_slot;

    assign run         = (state_reg == RUN);
    assign accept      = Sample_Valid && !hold_valid_reg;
    // Start from IDLE, or chain directly onto the end of the current frame
    assign frame_start = Enable && hold_valid_reg && ((state_reg == IDLE) || frame_end);
    assign load_slot   = (slot_idx == SLOT_FIRST) || (slot_idx == SLOT_MID);

    bit_slot_timer #(
        .BIT_PERIOD (BIT_PERIOD)
    ) u_timer (
        .clk        (CLOCK_50),
        .rst_n      (Reset_n),
        .start      (frame_start),
        .run        (run),
        .frame_end  (frame_end),
        .slot_start (slot_start),
        .slot_idx   (slot_idx),
        .bit_clock  (bit_clock_next),
        .active     (active_next)
    );

    // Frame sequencing: a frame never stops early, only at frame_end
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (frame_start) state_next = RUN;
            RUN:     if (frame_end)   state_next = frame_start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Holding register; a simultaneous accept wins so the new sample is kept
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else if (accept) begin
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= Sample_Data;
        end else if (frame_start) begin
            hold_valid_reg <= 1'b0;
        end
    end

    // Frame register and the byte presented to the PISO on each load
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_lo_reg      <= '0;
            parallel_data_reg <= '0;
        end else if (frame_start) begin
            frame_lo_reg      <= hold_data_reg[DATA_W-1:0];
            parallel_data_reg <= hold_data_reg[SAMPLE_W-1:DATA_W];
        end else if (slot_start && (slot_idx == SLOT_MID)) begin
            parallel_data_reg <= frame_lo_reg;
        end
    end

    // Registered PISO controls, bit clock, frame sync and underrun pulse
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            load_reg       <= 1'b0;
            shift_reg      <= 1'b0;
            bit_clock_reg  <= 1'b0;
            frame_sync_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            load_reg       <= slot_start && load_slot;
            shift_reg      <= slot_start && !load_slot;
            bit_clock_reg  <= bit_clock_next;
            frame_sync_reg <= active_next && (slot_idx == SLOT_FIRST);
            underrun_reg   <= frame_end && Enable && !hold_valid_reg;
        end
    end

    assign Sample_Ready       = ~hold_valid_reg;
    assign Parallel_Data      = parallel_data_reg;
    assign Load_Parallel_Data = load_reg;
    assign Shift_Flag         = shift_reg;
    assign Bit_Clock          = bit_clock_reg;
    assign Frame_Sync         = frame_sync_reg;
    assign Busy               = run;
    assign Underrun           = underrun_reg;

endmodule

// File: tb/tb_piso_tx_controller.sv
// Directed bench for piso_tx_controller with BIT_PERIOD = 4.
module tb_piso_tx_controller;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  parallel_data;
    logic        load;
    logic        shift;
    logic        bit_clock;
    logic        frame_sync;
    logic        busy;
    logic        underrun;

    int n_cmp = 0;
    int n_bad = 0;

    piso_tx_controller #(.BIT_PERIOD(4)) dut (
        .CLOCK_50           (clk),
        .Reset_n            (rst_n),
        .Enable             (enable),
        .Sample_Data        (sample_data),
        .Sample_Valid       (sample_valid),
        .Sample_Ready       (sample_ready),
        .Parallel_Data      (parallel_data),
        .Load_Parallel_Data (load),
        .Shift_Flag         (shift),
        .Bit_Clock          (bit_clock),
        .Frame_Sync         (frame_sync),
        .Busy               (busy),
        .Underrun           (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor: loads, underruns and Ready transitions
    int          cyc_n = 0;
    logic [7:0]  load_q[$];
    int          load_t[$];
    int          un_cnt = 0;
    int          ready_tog = 0;
    logic        ready_prev = 1'b1;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (load) begin
            load_q.push_back(parallel_data);
            load_t.push_back(cyc_n);
        end
        if (underrun) un_cnt = un_cnt + 1;
        if (sample_ready !== ready_prev) ready_tog = ready_tog + 1;
        ready_prev = sample_ready;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Clear monitor state mid-cycle so it cannot race the monitor itself
    task automatic clear_mon();
        @(negedge clk);
        #1;
        load_q.delete();
        load_t.delete();
        un_cnt     = 0;
        ready_tog  = 0;
        ready_prev = sample_ready;
    endtask

    // Offer one sample; returns at the negedge after the accepting edge
    task automatic send(input logic [15:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        for (int i = 0; i < 300 && !sample_ready; i++) @(negedge clk);
        check("send_ready", sample_ready, 1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_nloads(input int n, input string name);
        for (int i = 0; i < 600 && load_q.size() < n; i++) @(negedge clk);
        check(name, load_q.size(), n);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 600 && busy; i++) @(negedge clk);
        check(name, busy, 0);
    endtask

    task automatic check_byte(input string name, input int k, input logic [7:0] exp);
        check(name, (k < load_q.size()) ? load_q[k] : 8'hxx, exp);
    endtask

    typedef struct {
        logic [15:0] sample;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
        logic [15:0] exp_bits;
    } vec_t;

    vec_t vecs[3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hA541, 8'hA5, 8'h41, 16'b1010010101000001};
        vecs[1] = '{16'h0001, 8'h00, 8'h01, 16'b0000000000000001};
        vecs[2] = '{16'hFF80, 8'hFF, 8'h80, 16'b1111111110000000};

        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;

        // Reset state
        #2;
        check("rst_ready", sample_ready, 1);
        check("rst_load", load, 0);
        check("rst_shift", shift, 0);
        check("rst_pdata", parallel_data, 0);
        check("rst_busy", busy, 0);
        check("rst_bclk", bit_clock, 0);
        check("rst_fsync", frame_sync, 0);
        check("rst_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Single-frame vectors: full cycle-by-cycle frame shape
        for (int v = 0; v < 3; v++) begin
            logic [7:0]  piso;
            logic [15:0] bits;
            int          nbits;
            piso  = '0;
            bits  = '0;
            nbits = 0;
            send(vecs[v].sample);
            check("lat_ready_low", sample_ready, 0);
            check("lat_no_load", load, 0);
            @(negedge clk);
            for (int off = 0; off < 64; off++) begin
                if (off > 0) @(negedge clk);
                check("f_load", load, (off == 0) || (off == 32));
                check("f_shift", shift, (off % 4 == 0) && (off != 0) && (off != 32));
                check("f_fsync", frame_sync, off < 4);
                check("f_bclk", bit_clock, (off % 4) >= 2);
                check("f_busy", busy, 1);
                check("f_underrun", underrun, 0);
                check("f_pdata", parallel_data, (off < 32) ? vecs[v].exp_hi : vecs[v].exp_lo);
                if (load) begin
                    piso  = parallel_data;
                    bits  = {bits[14:0], piso[7]};
                    nbits++;
                end else if (shift) begin
                    piso  = {piso[6:0], 1'b0};
                    bits  = {bits[14:0], piso[7]};
                    nbits++;
                end
            end
            @(negedge clk);
            check("end_busy", busy, 0);
            check("end_underrun", underrun, 1);
            check("end_bclk", bit_clock, 0);
            check("end_load", load, 0);
            @(negedge clk);
            check("end_underrun_once", underrun, 0);
            check("serial_nbits", nbits, 16);
            check("serial_bits", bits, vecs[v].exp_bits);
            $display("frame %0h: serial %b", vecs[v].sample, bits);
        end

        // Back-to-back: second sample offered during the first frame
        clear_mon();
        send(16'h1234);
        wait_nloads(1, "b2b_load1");
        repeat (10) @(negedge clk);
        send(16'hABCD);
        check("b2b_ready_low", sample_ready, 0);
        wait_nloads(3, "b2b_load3");
        check("b2b_pdata_ab", parallel_data, 8'hAB);
        enable = 1'b0;
        wait_idle("b2b_idle");
        @(negedge clk);
        check_byte("b2b_b0", 0, 8'h12);
        check_byte("b2b_b1", 1, 8'h34);
        check_byte("b2b_b2", 2, 8'hAB);
        check_byte("b2b_b3", 3, 8'hCD);
        check("b2b_gap", (load_t.size() > 2) ? load_t[2] - load_t[0] : -1, 64);
        check("b2b_underrun", un_cnt, 0);
        $display("back-to-back 1234/ABCD: %0d loads, %0d underruns", load_q.size(), un_cnt);

        // Valid held high with three samples queued
        begin
            logic [15:0] s3 [3];
            logic [7:0]  e3 [6];
            s3 = '{16'h1234, 16'h5678, 16'h9ABC};
            e3 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
            enable = 1'b1;
            clear_mon();
            sample_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                sample_data = s3[k];
                for (int i = 0; i < 300 && !sample_ready; i++) @(negedge clk);
                check("q_ready", sample_ready, 1);
                @(negedge clk);
            end
            sample_valid = 1'b0;
            wait_nloads(6, "q_loads");
            wait_idle("q_idle");
            @(negedge clk);
            for (int k = 0; k < 6; k++) check_byte("q_byte", k, e3[k]);
            check("q_gap1", (load_t.size() > 2) ? load_t[2] - load_t[0] : -1, 64);
            check("q_gap2", (load_t.size() > 4) ? load_t[4] - load_t[2] : -1, 64);
            check("q_ready_toggles", ready_tog, 6);
            check("q_underrun", un_cnt, 1);
            $display("queued stream: %0d loads, %0d ready toggles", load_q.size(), ready_tog);
        end

        // Enable dropped at slot 5
        begin
            int t0;
            enable = 1'b1;
            clear_mon();
            send(16'hC3A5);
            wait_nloads(1, "en_load1");
            t0 = (load_t.size() > 0) ? load_t[0] : 0;
            repeat (20) @(negedge clk);
            enable = 1'b0;
            send(16'h5A0F);
            wait_idle("en_idle");
            check("en_frame_len", cyc_n - t0, 64);
            repeat (10) @(negedge clk);
            check("en_nloads", load_q.size(), 2);
            check_byte("en_b0", 0, 8'hC3);
            check_byte("en_b1", 1, 8'hA5);
            check("en_busy", busy, 0);
            check("en_underrun", un_cnt, 0);
            check("en_held", sample_ready, 0);
            enable = 1'b1;
            @(negedge clk);
            check("en_restart_load", load, 1);
            check("en_restart_pdata", parallel_data, 8'h5A);
            enable = 1'b0;
            wait_idle("en_idle2");
            @(negedge clk);
            check_byte("en_b3", 3, 8'h0F);
            check("en_underrun2", un_cnt, 0);
            $display("enable drop: frame length %0d, %0d loads", 64, load_q.size());
        end

        // Asynchronous reset at slot 10
        enable = 1'b1;
        clear_mon();
        send(16'h6789);
        wait_nloads(1, "rs_load1");
        repeat (40) @(negedge clk);
        check("rs_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_ready", sample_ready, 1);
        check("rs_load", load, 0);
        check("rs_shift", shift, 0);
        check("rs_pdata", parallel_data, 0);
        check("rs_busy", busy, 0);
        check("rs_bclk", bit_clock, 0);
        check("rs_fsync", frame_sync, 0);
        check("rs_underrun", underrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (80) @(negedge clk);
        check("rs_no_load", load_q.size(), 0);
        check("rs_idle", busy, 0);
        send(16'h4321);
        wait_nloads(1, "rs_new_load");
        check_byte("rs_new_byte", 0, 8'h43);
        enable = 1'b0;
        wait_idle("rs_idle2");
        $display("reset mid-frame: recovered with byte %0h", (load_q.size() > 0) ? load_q[0] : 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
